// File: rtl/pipe_mem_wb.sv
// Memory-to-writeback pipeline register: STAGES deep, with stall/flush, result mux and RAW hazards.
// Define PIPE_MEM_WB_STATS_EN to add the retired_count / bubble_count counters.
module pipe_mem_wb #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WRITE_WIDTH = 5,
    parameter int unsigned STAGES      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   validm,
    input  logic                   regwritem,
    input  logic [1:0]             resultsrcm,
    input  logic [DATA_WIDTH-1:0]  aluresultm,
    input  logic [DATA_WIDTH-1:0]  readdatam,
    input  logic [WRITE_WIDTH-1:0] rdm,
    input  logic [DATA_WIDTH-1:0]  pcplus4m,
    input  logic [WRITE_WIDTH-1:0] rs1e,
    input  logic [WRITE_WIDTH-1:0] rs2e,
    output logic                   validw,
    output logic                   regwritew,
    output logic [1:0]             resultsrcw,
    output logic [DATA_WIDTH-1:0]  aluresultw,
    output logic [DATA_WIDTH-1:0]  readdataw,
    output logic [WRITE_WIDTH-1:0] rdw,
    output logic [DATA_WIDTH-1:0]  pcplus4w,
    output logic [DATA_WIDTH-1:0]  resultw,
`ifdef PIPE_MEM_WB_STATS_EN
    output logic [31:0]            retired_count,
    output logic [31:0]            bubble_count,
`endif
    output logic                   hazard_rs1,
    output logic                   hazard_rs2
);

    if ((STAGES == 0) || (STAGES > 4)) begin : g_bad_stages
        $error("pipe_mem_wb: STAGES must be in 1..4");
    end

    localparam int NStg = int'(STAGES);
    localparam int Last = NStg - 1;

    logic                   valid_q     [NStg];
    logic                   regwrite_q  [NStg];
    logic [1:0]             resultsrc_q [NStg];
    logic [DATA_WIDTH-1:0]  aluresult_q [NStg];
    logic [DATA_WIDTH-1:0]  readdata_q  [NStg];
    logic [WRITE_WIDTH-1:0] rd_q        [NStg];
    logic [DATA_WIDTH-1:0]  pcplus4_q   [NStg];

    // Flush only clears valid bits; payloads keep their stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NStg; k++) begin
                valid_q[k]     <= 1'b0;
                regwrite_q[k]  <= 1'b0;
                resultsrc_q[k] <= '0;
                aluresult_q[k] <= '0;
                readdata_q[k]  <= '0;
                rd_q[k]        <= '0;
                pcplus4_q[k]   <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NStg; k++) begin
                valid_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0]     <= validm;
            regwrite_q[0]  <= regwritem;
            resultsrc_q[0] <= resultsrcm;
            aluresult_q[0] <= aluresultm;
            readdata_q[0]  <= readdatam;
            rd_q[0]        <= rdm;
            pcplus4_q[0]   <= pcplus4m;
            for (int k = 1; k < NStg; k++) begin
                valid_q[k]     <= valid_q[k-1];
                regwrite_q[k]  <= regwrite_q[k-1];
                resultsrc_q[k] <= resultsrc_q[k-1];
                aluresult_q[k] <= aluresult_q[k-1];
                readdata_q[k]  <= readdata_q[k-1];
                rd_q[k]        <= rd_q[k-1];
                pcplus4_q[k]   <= pcplus4_q[k-1];
            end
        end
    end

    assign validw     = valid_q[Last];
    assign regwritew  = regwrite_q[Last] & valid_q[Last];
    assign resultsrcw = resultsrc_q[Last];
    assign aluresultw = aluresult_q[Last];
    assign readdataw  = readdata_q[Last];
    assign rdw        = rd_q[Last];
    assign pcplus4w   = pcplus4_q[Last];

    always_comb begin
        resultw = '0;
        if (validw) begin
            unique case (resultsrcw)
                2'b00:   resultw = aluresultw;
                2'b01:   resultw = readdataw;
                2'b10:   resultw = pcplus4w;
                default: resultw = '0;
            endcase
        end
    end

    // The final stage is excluded: its value is forwarded from resultw instead.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int k = 0; k < Last; k++) begin
            if (valid_q[k] && regwrite_q[k] && (rd_q[k] != '0)) begin
                if (rd_q[k] == rs1e) hazard_rs1 = 1'b1;
                if (rd_q[k] == rs2e) hazard_rs2 = 1'b1;
            end
        end
    end

`ifdef PIPE_MEM_WB_STATS_EN
    logic [31:0] retired_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else if (!stall && !flush) begin
            if (validw) retired_q <= retired_q + 32'd1;
            else        bubble_q  <= bubble_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
    assign bubble_count  = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Bench for pipe_mem_wb: three lanes (STAGES=1,2,3) share one stimulus stream; per-lane scoreboards
// check every W-stage arrival, with directed checks for reset, stall, flush, hazards and counters.
module tb_pipe_mem_wb;
    localparam int NL = 3;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
        logic [31:0] res;
        int unsigned arrive;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, validm, regwritem;
    logic [1:0]  resultsrcm;
    logic [31:0] aluresultm, readdatam, pcplus4m;
    logic [4:0]  rdm, rs1e, rs2e;
    logic [31:0] exp_res;

    logic        validw     [NL];
    logic        regwritew  [NL];
    logic [1:0]  resultsrcw [NL];
    logic [31:0] aluresultw [NL];
    logic [31:0] readdataw  [NL];
    logic [4:0]  rdw        [NL];
    logic [31:0] pcplus4w   [NL];
    logic [31:0] resultw    [NL];
    logic        hazard_rs1 [NL];
    logic        hazard_rs2 [NL];
`ifdef PIPE_MEM_WB_STATS_EN
    logic [31:0] retired_count [NL];
    logic [31:0] bubble_count  [NL];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        pipe_mem_wb #(
            .DATA_WIDTH (32),
            .WRITE_WIDTH(5),
            .STAGES     (g + 1)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .stall        (stall),
            .flush        (flush),
            .validm       (validm),
            .regwritem    (regwritem),
            .resultsrcm   (resultsrcm),
            .aluresultm   (aluresultm),
            .readdatam    (readdatam),
            .rdm          (rdm),
            .pcplus4m     (pcplus4m),
            .rs1e         (rs1e),
            .rs2e         (rs2e),
            .validw       (validw[g]),
            .regwritew    (regwritew[g]),
            .resultsrcw   (resultsrcw[g]),
            .aluresultw   (aluresultw[g]),
            .readdataw    (readdataw[g]),
            .rdw          (rdw[g]),
            .pcplus4w     (pcplus4w[g]),
            .resultw      (resultw[g]),
`ifdef PIPE_MEM_WB_STATS_EN
            .retired_count(retired_count[g]),
            .bubble_count (bubble_count[g]),
`endif
            .hazard_rs1   (hazard_rs1[g]),
            .hazard_rs2   (hazard_rs2[g])
        );

        exp_t        q[$];
        int unsigned adv_cnt = 0;
        logic        adv_last = 1'b0;

        // Capture: a valid issue on an advancing edge is due at W after g more advancing edges.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                adv_last <= 1'b0;
            end else if (flush) begin
                q.delete();
                adv_last <= 1'b0;
            end else if (stall) begin
                adv_last <= 1'b0;
            end else begin
                adv_cnt  <= adv_cnt + 1;
                adv_last <= 1'b1;
                if (validm) begin
                    q.push_back('{rd: rdm, rw: regwritem, src: resultsrcm, res: exp_res,
                                  arrive: adv_cnt + 1 + g});
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n && adv_last) begin
                if (validw[g]) begin
                    if (q.size() == 0) begin
                        check($sformatf("lane%0d_spurious_validw", g), validw[g], 1'b0);
                    end else begin
                        check($sformatf("lane%0d_latency", g), adv_cnt, q[0].arrive);
                        check($sformatf("lane%0d_rdw", g), rdw[g], q[0].rd);
                        check($sformatf("lane%0d_regwritew", g), regwritew[g], q[0].rw);
                        check($sformatf("lane%0d_resultsrcw", g), resultsrcw[g], q[0].src);
                        check($sformatf("lane%0d_resultw", g), resultw[g], q[0].res);
                        q.delete(0);
                    end
                end else if (q.size() != 0 && q[0].arrive == adv_cnt) begin
                    check($sformatf("lane%0d_missing_validw", g), validw[g], 1'b1);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
        validm     = v;
        regwritem  = rw;
        resultsrcm = src;
        aluresultm = alu;
        readdatam  = rdata;
        pcplus4m   = pc;
        rdm        = rd;
        exp_res    = res;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        validm    = 1'b0;
        regwritem = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rs1e  = '0;
        rs2e  = '0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
        #1;
        for (int i = 0; i < NL; i++) begin
            check($sformatf("rst_validw%0d", i), validw[i], 1'b0);
            check($sformatf("rst_regwritew%0d", i), regwritew[i], 1'b0);
            check($sformatf("rst_resultw%0d", i), resultw[i], 32'h0);
            check($sformatf("rst_rdw%0d", i), rdw[i], 5'd0);
            check($sformatf("rst_haz1_%0d", i), hazard_rs1[i], 1'b0);
            check($sformatf("rst_haz2_%0d", i), hazard_rs2[i], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU result through STAGES=1
        drive(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5, 32'h1234);
        step();
        check("t1_validw", validw[0], 1'b1);
        check("t1_regwritew", regwritew[0], 1'b1);
        check("t1_rdw", rdw[0], 5'd5);
        check("t1_resultw", resultw[0], 32'h1234);
        idle(3);

        // Mux selects, regwrite=0, and an invalid issue
        drive(1'b1, 1'b1, 2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 32'h200, 5'd3, 32'hDEAD_BEEF);
        step();
        drive(1'b1, 1'b1, 2'b11, 32'h2222_2222, 32'h3333_3333, 32'h204, 5'd6, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'b00, 32'h0000_CAFE, 32'h0, 32'h208, 5'd8, 32'h0000_CAFE);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'h0000_0BAD, 32'h0, 32'h20C, 5'd9, 32'h0000_0BAD);
        step();
        idle(4);

        // STAGES=3 latency and hazard window
        rs1e = 5'd7;
        rs2e = 5'd3;
        drive(1'b1, 1'b1, 2'b10, 32'h0000_AAAA, 32'h0000_5555, 32'h104, 5'd7, 32'h104);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
        check("t2_haz1_s0_l2", hazard_rs1[2], 1'b1);
        check("t2_haz1_s0_l1", hazard_rs1[1], 1'b1);
        check("t2_haz1_l0", hazard_rs1[0], 1'b0);
        check("t2_haz2_l2", hazard_rs2[2], 1'b0);
        check("t2_validw_l2_early", validw[2], 1'b0);
        step();
        check("t2_haz1_s1_l2", hazard_rs1[2], 1'b1);
        check("t2_haz1_final_l1", hazard_rs1[1], 1'b0);
        rs2e = 5'd7;
        #1;
        check("t2_haz2_s1_l2", hazard_rs2[2], 1'b1);
        step();
        check("t2_haz1_final_l2", hazard_rs1[2], 1'b0);
        check("t2_validw_l2", validw[2], 1'b1);
        check("t2_resultw_l2", resultw[2], 32'h104);
        check("t2_aluresultw_l2", aluresultw[2], 32'h0000_AAAA);
        check("t2_readdataw_l2", readdataw[2], 32'h0000_5555);
        check("t2_pcplus4w_l2", pcplus4w[2], 32'h104);
        idle(3);

        // Stall holds every stage
        rs1e = 5'd9;
        rs2e = 5'd0;
        drive(1'b1, 1'b1, 2'b00, 32'h99, 32'h0, 32'h300, 5'd9, 32'h99);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
        stall     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("t3_stall%0d_validw_l1", c), validw[1], 1'b0);
            check($sformatf("t3_stall%0d_haz1_l1", c), hazard_rs1[1], 1'b1);
            check($sformatf("t3_stall%0d_validw_l0", c), validw[0], 1'b1);
            check($sformatf("t3_stall%0d_resultw_l0", c), resultw[0], 32'h99);
        end
        stall = 1'b0;
        step();
        check("t3_validw_l1", validw[1], 1'b1);
        check("t3_resultw_l1", resultw[1], 32'h99);
        idle(3);

        // Flush wins over stall
        rs1e = 5'd11;
        drive(1'b1, 1'b1, 2'b00, 32'hA1, 32'h0, 32'h400, 5'd10, 32'hA1);
        step();
        drive(1'b1, 1'b1, 2'b00, 32'hB2, 32'h0, 32'h404, 5'd11, 32'hB2);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
        check("t4_haz1_pre_l2", hazard_rs1[2], 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < NL; i++) begin
            check($sformatf("t4_validw%0d", i), validw[i], 1'b0);
            check($sformatf("t4_regwritew%0d", i), regwritew[i], 1'b0);
            check($sformatf("t4_resultw%0d", i), resultw[i], 32'h0);
            check($sformatf("t4_haz1_%0d", i), hazard_rs1[i], 1'b0);
        end
        idle(3);

        // rd=0 never raises a hazard
        rs1e = 5'd0;
        rs2e = 5'd0;
        drive(1'b1, 1'b1, 2'b00, 32'h55, 32'h0, 32'h500, 5'd0, 32'h55);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
        check("t5_haz1_rd0_l1", hazard_rs1[1], 1'b0);
        check("t5_haz2_rd0_l2", hazard_rs2[2], 1'b0);
        idle(3);

        // Asynchronous reset mid-cycle
        rs1e = 5'd4;
        drive(1'b1, 1'b1, 2'b00, 32'h44, 32'h0, 32'h600, 5'd4, 32'h44);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
        check("t5_haz1_pre_l1", hazard_rs1[1], 1'b1);
        step();
        check("t5_validw_pre_l1", validw[1], 1'b1);
        check("t5_haz1_pre_l2", hazard_rs1[2], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_arst_validw_l1", validw[1], 1'b0);
        check("t5_arst_regwritew_l1", regwritew[1], 1'b0);
        check("t5_arst_resultw_l1", resultw[1], 32'h0);
        check("t5_arst_rdw_l1", rdw[1], 5'd0);
        check("t5_arst_haz1_l2", hazard_rs1[2], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 valid + 2 invalid issues, then drain
        drive(1'b1, 1'b1, 2'b00, 32'h71, 32'h0, 32'h700, 5'd1, 32'h71);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'h72, 32'h0, 32'h704, 5'd2, 32'h72);
        step();
        drive(1'b1, 1'b1, 2'b01, 32'h0, 32'h73, 32'h708, 5'd3, 32'h73);
        step();
        drive(1'b0, 1'b1, 2'b00, 32'h74, 32'h0, 32'h70C, 5'd4, 32'h74);
        step();
        drive(1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h710, 5'd5, 32'h710);
        step();
        idle(2);
`ifdef PIPE_MEM_WB_STATS_EN
        check("t6_retired", retired_count[0], 32'd3);
        check("t6_bubble", bubble_count[0], 32'd4);
        force g_lane[0].u_dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release g_lane[0].u_dut.retired_q;
`endif
        drive(1'b1, 1'b1, 2'b00, 32'h81, 32'h0, 32'h800, 5'd6, 32'h81);
        step();
        validm    = 1'b0;
        regwritem = 1'b0;
`ifdef PIPE_MEM_WB_STATS_EN
        check("t6_retired_preload", retired_count[0], 32'hFFFF_FFFF);
`endif
        step();
`ifdef PIPE_MEM_WB_STATS_EN
        check("t6_retired_wrap", retired_count[0], 32'h0);
`endif
        idle(4);

        check("drain_q0", g_lane[0].q.size(), 32'd0);
        check("drain_q1", g_lane[1].q.size(), 32'd0);
        check("drain_q2", g_lane[2].q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
